// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: word-level transmit FIFO feeding the 4-byte UART transmit
// buffer stage. Words of {is_b, data} are queued in a circular buffer and
// handed to the buffer stage one at a time through a start/busy handshake.
//
// Optional feature: define UART_TX_FIFO_OVF_EN to add a sticky `overflow`
// output that records any write attempted while the FIFO is full.

`timescale 1ns/1ps

module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wdata,
    input  logic        wr_is_b,
    input  logic        wr_en,
    output logic        full,
    output logic        empty,
    output logic [31:0] sdata,
    output logic        is_b,
    output logic        tx_buf_start,
    input  logic        tx_buf_busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic        overflow
`endif
);

    // Pointer width is derived from the depth and never set independently.
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StDone
    } state_e;

    // Storage and pointers.
    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    // Drain FSM and its registered outputs.
    state_e        state_q, state_d;
    logic          start_q, start_d;
    logic [31:0]   sdata_q, sdata_d;
    logic          is_b_q, is_b_d;

    logic          push;
    logic          pop;

    // A write is taken only when the FIFO was not full before this edge; a pop in the
    // same cycle does not make room for it.
    assign push = wr_en && !full_q;

    // A pop happens only on the IDLE->ACK transition. It is gated by the registered
    // empty flag, so a word written this cycle cannot also leave this cycle.
    assign pop = (state_q == StIdle) && !empty_q && !tx_buf_busy;

    // Drain FSM next state: issue one word, wait for busy to rise, then wait for it to fall.
    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        sdata_d  = sdata_q;
        is_b_d   = is_b_q;
        rd_ptr_d = rd_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    {is_b_d, sdata_d} = mem_q[rd_ptr_q];
                    rd_ptr_d          = rd_ptr_q + AW'(1);
                    start_d           = 1'b1;
                    state_d           = StAck;
                end
            end
            StAck: begin
                if (tx_buf_busy) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!tx_buf_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Occupancy bookkeeping: pointers, count and the registered full/empty flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW + 1)'(1);
        end
        full_d  = (count_d == FullCnt);
        empty_d = (count_d == '0);
    end

    // Entry storage. Left unreset: reset empties the FIFO through the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wr_is_b, wdata};
        end
    end

    // FSM state, registered drain outputs and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            start_q  <= 1'b0;
            sdata_q  <= '0;
            is_b_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            sdata_q  <= sdata_d;
            is_b_q   <= is_b_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign full         = full_q;
    assign empty        = empty_q;
    assign sdata        = sdata_q;
    assign is_b         = is_b_q;
    assign tx_buf_start = start_q;

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // Sticky drop flag: any write attempt against a full FIFO sets it until reset.
    always_comb begin
        ovf_d = ovf_q | (wr_en & full_q);
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized
// traffic, scored against a queue model of the FIFO contents.

`timescale 1ns/1ps

module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wdata;
    logic        wr_is_b;
    logic        wr_en;
    logic        full;
    logic        empty;
    logic [31:0] sdata;
    logic        is_b;
    logic        tx_buf_start;
    logic        tx_buf_busy;
    logic        busy_gen;
    logic        hold_busy;
`ifdef UART_TX_FIFO_OVF_EN
    logic        overflow;
    logic        ovf_exp;
`endif

    int          checks = 0;
    int          errors = 0;
    int          issued = 0;
    bit          chk_en = 0;
    bit          long_hold = 0;
    logic [32:0] exp_q[$];

    assign tx_buf_busy = busy_gen | hold_busy;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wdata       (wdata),
        .wr_is_b     (wr_is_b),
        .wr_en       (wr_en),
        .full        (full),
        .empty       (empty),
        .sdata       (sdata),
        .is_b        (is_b),
        .tx_buf_start(tx_buf_start),
        .tx_buf_busy (tx_buf_busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue of accepted words; writes against a full queue drop.
    initial begin
`ifdef UART_TX_FIFO_OVF_EN
        ovf_exp = 1'b0;
`endif
        forever begin
            @(posedge clk);
            if (rst === 1'b1) begin
                exp_q.delete();
`ifdef UART_TX_FIFO_OVF_EN
                ovf_exp = 1'b0;
`endif
            end else if (wr_en === 1'b1) begin
                if (exp_q.size() == DEPTH) begin
`ifdef UART_TX_FIFO_OVF_EN
                    ovf_exp = 1'b1;
`endif
                end else begin
                    exp_q.push_back({wr_is_b, wdata});
                end
            end
        end
    end

    // Monitor: every start pulse pops the scoreboard; also polices the start/busy protocol.
    initial begin
        bit          prev_start = 0;
        bit          armed = 1;
        bit          seen_rise = 0;
        logic [32:0] exp_w;
        forever begin
            @(posedge clk);
            #1;
            if (tx_buf_start === 1'b1) begin
                issued++;
                check_eq("start_width", 64'(prev_start), 64'd0);
                check_eq("start_rearm", 64'(armed), 64'd1);
                check_eq("issue_when_queued", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check_eq("issue_word", 64'({is_b, sdata}), 64'(exp_w));
                end
                armed     = 0;
                seen_rise = 0;
            end else if (!armed) begin
                if (tx_buf_busy === 1'b1) begin
                    seen_rise = 1;
                end else if (seen_rise) begin
                    armed = 1;
                end
            end
            prev_start = (tx_buf_start === 1'b1);
        end
    end

    // Flag checker: full/empty (and overflow) must track the model's occupancy after each edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check_eq("full_flag", 64'(full), 64'(exp_q.size() == DEPTH));
                check_eq("empty_flag", 64'(empty), 64'(exp_q.size() == 0));
`ifdef UART_TX_FIFO_OVF_EN
                check_eq("overflow_flag", 64'(overflow), 64'(ovf_exp));
`endif
            end
        end
    end

    // Buffer-stage model: raises busy a little after each start and holds it for a while.
    initial begin
        int h;
        busy_gen = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_buf_start === 1'b1) begin
                repeat ($urandom_range(1, 2)) @(negedge clk);
                busy_gen = 1'b1;
                h = long_hold ? 40 : int'($urandom_range(1, 6));
                repeat (h) @(negedge clk);
                busy_gen = 1'b0;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [31:0] d, input logic b);
        wdata   = d;
        wr_is_b = b;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        int stable = 0;
        while (n < 3000 && stable < 4) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && tx_buf_busy === 1'b0 && tx_buf_start === 1'b0) begin
                stable++;
            end else begin
                stable = 0;
            end
        end
        check_eq({name, "_drain"}, 64'(stable >= 4), 64'd1);
    endtask

    initial begin
        int base;
        int n;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wdata     = '0;
        wr_is_b   = 1'b0;
        hold_busy = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk_en = 1;
        check_eq("rst_empty", 64'(empty), 64'd1);
        check_eq("rst_full", 64'(full), 64'd0);
        check_eq("rst_start", 64'(tx_buf_start), 64'd0);
        check_eq("rst_sdata", 64'(sdata), 64'd0);
        check_eq("rst_is_b", 64'(is_b), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single word latency: start exactly in cycle 2 after the write cycle.
        push(32'hDEADBEEF, 1'b1);
        check_eq("t1_start_c1", 64'(tx_buf_start), 64'd0);
        @(negedge clk);
        check_eq("t1_start_c2", 64'(tx_buf_start), 64'd1);
        check_eq("t1_sdata", 64'(sdata), 64'hDEADBEEF);
        check_eq("t1_is_b", 64'(is_b), 64'd1);
        @(negedge clk);
        check_eq("t1_start_c3", 64'(tx_buf_start), 64'd0);
        check_eq("t1_empty_c3", 64'(empty), 64'd1);
        wait_idle("t1");

        // Fill to full under busy, drop one write, then push on the pop cycle.
        hold_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push(32'(i), 1'(i % 2));
        end
        check_eq("fill_full", 64'(full), 64'd1);
        push(32'h99, 1'b0);
        check_eq("drop_full", 64'(full), 64'd1);
`ifdef UART_TX_FIFO_OVF_EN
        check_eq("drop_overflow", 64'(overflow), 64'd1);
`endif
        wdata     = 32'h77;
        wr_is_b   = 1'b1;
        wr_en     = 1'b1;
        hold_busy = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        check_eq("pop_full_start", 64'(tx_buf_start), 64'd1);
        check_eq("pop_full_falls", 64'(full), 64'd0);
        wait_idle("fill");

        // Three words against a slow buffer stage.
        long_hold = 1;
        base = issued;
        for (int i = 0; i < 3; i++) begin
            push(32'hA000_0000 + 32'(i), 1'b0);
        end
        wait_idle("slow");
        check_eq("slow_pulses", 64'(issued - base), 64'd3);
        long_hold = 0;

        // Randomized traffic, long enough to wrap the pointers several times.
        for (int i = 0; i < 500; i++) begin
            wdata   = $urandom;
            wr_is_b = 1'($urandom_range(0, 1));
            wr_en   = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        wait_idle("random");

        // Reset while the FSM waits in DONE with words still queued.
        long_hold = 1;
        for (int i = 0; i < 5; i++) begin
            push(32'hC000_0000 + 32'(i), 1'b1);
        end
        n = 0;
        while (busy_gen !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_busy_seen", 64'(busy_gen), 64'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_empty", 64'(empty), 64'd1);
        check_eq("t6_sdata", 64'(sdata), 64'd0);
        check_eq("t6_start", 64'(tx_buf_start), 64'd0);
        base = issued;
        n = 0;
        while (tx_buf_busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check_eq("t6_no_issue", 64'(issued - base), 64'd0);
        long_hold = 0;
        push(32'h1234_5678, 1'b0);
        wait_idle("t6");
        check_eq("t6_new_issue", 64'(issued - base), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
